av2_tile_sequencer: RTL and testbench
=====================================

# av2_tile_sequencer

Frame-level controller that drives one `av2_tile_decoder_real` instance across every tile of a frame. It splits the frame into raster-ordered tiles, issues one start pulse per tile with its clipped origin and size, and waits for `tile_done`. It counts reconstruction writes per tile and per frame, and guards each tile with a watchdog. It sits between the frame-header parser and the tile decoder.

## Interface
Parameters:
- `TILE_LOG2`, 6 — tile edge is 2^TILE_LOG2 pixels (square tiles).
- `TIMEOUT_CYCLES`, 1000000 — per-tile watchdog limit, in cycles.
- `CNT_W`, 32 — width of the write counters.

Ports:
- `clk` in 1 — single clock; all logic is on its rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `frame_start` in 1 — start request; accepted only in IDLE.
- `frame_width` in 16 — frame width in pixels; sampled when `frame_start` is accepted.
- `frame_height` in 16 — frame height in pixels; sampled when `frame_start` is accepted.
- `busy` out 1 — high in every state except IDLE.
- `frame_done` out 1 — one-cycle pulse when all tiles have finished.
- `frame_error` out 1 — one-cycle pulse on watchdog expiry or zero frame size.
- `err_tile_idx` out 16 — raster index of the failing tile; held until the next accepted start.
- `tile_start` out 1 — one-cycle start pulse to the tile decoder.
- `tile_x` out 16 — origin of the current tile, in pixels.
- `tile_y` out 16 — origin of the current tile, in pixels.
- `tile_w` out 16 — clipped size of the current tile.
- `tile_h` out 16 — clipped size of the current tile.
- `tile_done` in 1 — completion from the tile decoder.
- `recon_wr_en` in 1 — monitored write strobe from the tile decoder.
- `tile_wr_count` out CNT_W — writes seen during the current tile.
- `frame_wr_count` out CNT_W — writes seen during the current frame.
- `tiles_done` out 16 — number of tiles completed in this frame.

## Operation
- Tile grid:
  - tiles_x = ceil(W / 2^TILE_LOG2); tiles_y = ceil(H / 2^TILE_LOG2). Both are computed with shift-and-add, no divider.
  - tile_w = min(2^TILE_LOG2, W − tile_x); tile_h is computed the same way from H and tile_y.
- States: IDLE, LAUNCH, RUN, DONE, ERR.
- IDLE:
  - On `frame_start`, latch W and H, clear all counters, and set the tile index and origin to 0.
  - If W==0 or H==0, go to ERR with `err_tile_idx`=0. Otherwise go to LAUNCH.
- LAUNCH:
  - Assert `tile_start` for exactly one cycle.
  - Clear `tile_wr_count` and the watchdog.
  - Go to RUN.
- RUN:
  - The watchdog increments every cycle.
  - On `tile_done`, increment `tiles_done`.
    - If this was the last tile, go to DONE.
    - Otherwise advance x by 2^TILE_LOG2. On passing the row end, set x=0 and advance y by 2^TILE_LOG2. Then go to LAUNCH.
  - If the watchdog reaches TIMEOUT_CYCLES−1 without `tile_done`, go to ERR and latch `err_tile_idx`.
- DONE: pulse `frame_done`, then return to IDLE.
- ERR: pulse `frame_error`, then return to IDLE.
- Write counting:
  - `recon_wr_en` increments both counters in LAUNCH and RUN, including the cycle in which `tile_done` arrives.
  - It is ignored in all other states.
  - Both counters saturate at all-ones.
- Event rules:
  - `tile_done` outside RUN is ignored.
  - `frame_start` while busy is ignored.
  - If `tile_done` and watchdog expiry occur in the same cycle, `tile_done` wins.
- Held outputs:
  - `tile_x`, `tile_y`, `tile_w` and `tile_h` are registered and stable from LAUNCH through RUN.
  - Counters and `tiles_done` hold their values in IDLE until the next accepted start.

## Timing
- Reset (`rst` sampled high at a clock edge):
  - State returns to IDLE.
  - All outputs and counters go to 0, including `err_tile_idx`.
  - Reset mid-frame abandons the frame silently: no `frame_done` and no `frame_error` pulse.
- `frame_start` accepted at cycle 0 → `tile_start` is high in cycle 1.
- `tile_done` in cycle n:
  - Not the last tile → next `tile_start` in cycle n+1.
  - Last tile → `frame_done` in cycle n+1, and `busy` is low in cycle n+2.
- Minimum tile period is 2 cycles (LAUNCH, then RUN with `tile_done`).
- Zero-size frame: `frame_error` in cycle 1, and `busy` is low in cycle 2.
- Watchdog: with no `tile_done`, `frame_error` pulses TIMEOUT_CYCLES+1 cycles after the tile's `tile_start` cycle.

## Configuration
- `AV2_TILE_SEQ_WDOG_EN` defined:
  - The watchdog counter and the RUN→ERR transition are built.
  - `err_tile_idx` reports a timed-out tile.
- Not defined:
  - No watchdog logic is built, and RUN waits indefinitely for `tile_done`.
  - `frame_error` fires only for zero frame size, with `err_tile_idx`=0.

## Test plan
- 64×64 frame, TILE_LOG2=5, decoder answers `tile_done` 10 cycles after each `tile_start`:
  - Required: 4 `tile_start` pulses with origins (0,0), (32,0), (0,32), (32,32), each tile 32×32.
  - Required: `tiles_done`=4 and exactly one `frame_done`.
- 100×40 frame, TILE_LOG2=6:
  - Required: 2 tiles, (0,0) 64×40 and (64,0) 36×40.
  - Required: `frame_done` one cycle after the second `tile_done`.
- Drive `recon_wr_en` for 7 cycles in tile 0 and 5 cycles in tile 1, one strobe coinciding with `tile_done`:
  - Required: `tile_wr_count` reads 7 and then 5; `frame_wr_count`=12.
- Watchdog, built with `AV2_TILE_SEQ_WDOG_EN`, TIMEOUT_CYCLES=50, 64×64 frame, TILE_LOG2=5, `tile_done` withheld on tile 2:
  - Required: `frame_error` exactly 51 cycles after that tile's `tile_start`.
  - Required: `err_tile_idx`=2, `tiles_done`=2.
- Robustness:
  - `frame_start` while busy → ignored.
  - Stray `tile_done` in IDLE → ignored.
  - Zero width → `frame_error` in cycle 1.
- Reset mid-frame: assert `rst` during RUN of tile 1.
  - Required: all outputs are 0 in the next cycle, with no `frame_done` and no `frame_error`.
  - Required: a fresh `frame_start` decodes the frame normally.

Source files
------------

// File: rtl/av2_tile_sequencer_if.sv
// Tile-decoder bus of av2_tile_sequencer.
// master (sequencer) drives the launch pulse and the clipped tile geometry.
// slave (tile decoder) returns the completion pulse and its reconstruction write strobe.
interface av2_tile_sequencer_if;
  logic        tile_start;
  logic [15:0] tile_x;
  logic [15:0] tile_y;
  logic [15:0] tile_w;
  logic [15:0] tile_h;
  logic        tile_done;
  logic        recon_wr_en;

  modport master (
    output tile_start, tile_x, tile_y, tile_w, tile_h,
    input  tile_done, recon_wr_en
  );

  modport slave (
    input  tile_start, tile_x, tile_y, tile_w, tile_h,
    output tile_done, recon_wr_en
  );
endinterface

// File: rtl/av2_tile_sequencer.sv
// av2_tile_sequencer: walks one tile decoder across a frame in raster tile order.
// It issues one start pulse per tile with the clipped origin and size, counts
// reconstruction writes per tile and per frame, and reports completion or error.
// Optional build macro AV2_TILE_SEQ_WDOG_EN adds the per-tile watchdog
// (RUN -> ERR after TIMEOUT_CYCLES cycles without tile_done).
module av2_tile_sequencer #(
  parameter int unsigned TILE_LOG2      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [15:0]           err_tile_idx,
  av2_tile_sequencer_if.master  tile_bus,
  output logic [CNT_W-1:0]      tile_wr_count,
  output logic [CNT_W-1:0]      frame_wr_count,
  output logic [15:0]           tiles_done
);

  localparam logic [16:0] TILE = 17'd1 << TILE_LOG2;

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, ERR} state_t;

  state_t      state;
  logic [15:0] width_q;
  logic [15:0] height_q;
  logic [15:0] col;
  logic [15:0] row;
  logic [15:0] tile_idx;
  logic        start_pulse;
  logic [15:0] cur_x;
  logic [15:0] cur_y;
  logic [15:0] cur_w;
  logic [15:0] cur_h;
  logic [15:0] tiles_x;
  logic [15:0] tiles_y;
  logic [15:0] next_x;
  logic [15:0] next_y;
  logic        row_end;
  logic        last_tile;
`ifdef AV2_TILE_SEQ_WDOG_EN
  logic [31:0] wdog;
`endif

  assign tile_bus.tile_start = start_pulse;
  assign tile_bus.tile_x     = cur_x;
  assign tile_bus.tile_y     = cur_y;
  assign tile_bus.tile_w     = cur_w;
  assign tile_bus.tile_h     = cur_h;

  // Remaining extent from origin, capped at one tile edge.
  function automatic logic [15:0] clip(input logic [15:0] size, input logic [15:0] origin);
    logic [16:0] rem;
    rem = {1'b0, size} - {1'b0, origin};
    return (rem > TILE) ? TILE[15:0] : rem[15:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Tile grid size (ceil by add-and-shift) and raster advance of the origin.
  always_comb begin
    logic [16:0] span_x;
    logic [16:0] span_y;
    span_x    = {1'b0, width_q} + TILE - 17'd1;
    span_y    = {1'b0, height_q} + TILE - 17'd1;
    tiles_x   = 16'(span_x >> TILE_LOG2);
    tiles_y   = 16'(span_y >> TILE_LOG2);
    row_end   = (col == tiles_x - 16'd1);
    last_tile = row_end && (row == tiles_y - 16'd1);
    next_x    = cur_x + TILE[15:0];
    next_y    = cur_y;
    if (row_end) begin
      next_x = '0;
      next_y = cur_y + TILE[15:0];
    end
  end

  // Frame state machine with registered outputs and write counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      width_q        <= '0;
      height_q       <= '0;
      col            <= '0;
      row            <= '0;
      tile_idx       <= '0;
      start_pulse    <= 1'b0;
      cur_x          <= '0;
      cur_y          <= '0;
      cur_w          <= '0;
      cur_h          <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
      err_tile_idx   <= '0;
      tile_wr_count  <= '0;
      frame_wr_count <= '0;
      tiles_done     <= '0;
`ifdef AV2_TILE_SEQ_WDOG_EN
      wdog           <= '0;
`endif
    end else begin
      start_pulse <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;

      if ((state == LAUNCH || state == RUN) && tile_bus.recon_wr_en)
        frame_wr_count <= sat_inc(frame_wr_count);

      unique case (state)
        IDLE: begin
          if (frame_start) begin
            width_q        <= frame_width;
            height_q       <= frame_height;
            col            <= '0;
            row            <= '0;
            tile_idx       <= '0;
            cur_x          <= '0;
            cur_y          <= '0;
            tiles_done     <= '0;
            tile_wr_count  <= '0;
            frame_wr_count <= '0;
            err_tile_idx   <= '0;
            busy           <= 1'b1;
            if (frame_width == '0 || frame_height == '0) begin
              state       <= ERR;
              frame_error <= 1'b1;
            end else begin
              state       <= LAUNCH;
              start_pulse <= 1'b1;
              cur_w       <= clip(frame_width, '0);
              cur_h       <= clip(frame_height, '0);
            end
          end
        end
        LAUNCH: begin
          // The launch cycle itself already counts a write strobe.
          tile_wr_count <= tile_bus.recon_wr_en ? CNT_W'(1) : '0;
`ifdef AV2_TILE_SEQ_WDOG_EN
          wdog          <= '0;
`endif
          state         <= RUN;
        end
        RUN: begin
          if (tile_bus.recon_wr_en)
            tile_wr_count <= sat_inc(tile_wr_count);
`ifdef AV2_TILE_SEQ_WDOG_EN
          wdog <= wdog + 32'd1;
`endif
          if (tile_bus.tile_done) begin
            tiles_done <= tiles_done + 16'd1;
            if (last_tile) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state       <= LAUNCH;
              start_pulse <= 1'b1;
              tile_idx    <= tile_idx + 16'd1;
              cur_x       <= next_x;
              cur_y       <= next_y;
              cur_w       <= clip(width_q, next_x);
              cur_h       <= clip(height_q, next_y);
              col         <= row_end ? '0 : col + 16'd1;
              row         <= row_end ? row + 16'd1 : row;
            end
          end
`ifdef AV2_TILE_SEQ_WDOG_EN
          else if (wdog == 32'(TIMEOUT_CYCLES - 1)) begin
            state        <= ERR;
            frame_error  <= 1'b1;
            err_tile_idx <= tile_idx;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_av2_tile_sequencer.sv
// Directed, table-driven bench for av2_tile_sequencer.
// Two instances (TILE_LOG2 5 and 6) share the stimulus; sel6 picks which one is observed.
module tb_av2_tile_sequencer;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [15:0] frame_width;
  logic [15:0] frame_height;
  logic        tile_done;
  logic        recon_wr_en;
  logic        sel6;

  logic        busy5, fdone5, ferr5, busy6, fdone6, ferr6;
  logic [15:0] eidx5, tdn5, eidx6, tdn6;
  logic [31:0] twc5, fwc5, twc6, fwc6;

  typedef struct packed {
    logic        busy;
    logic        fdone;
    logic        ferr;
    logic [15:0] eidx;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
    logic [15:0] h;
    logic [31:0] twc;
    logic [31:0] fwc;
    logic [15:0] tdn;
  } obs_t;

  obs_t obs5, obs6, o;

  av2_tile_sequencer_if b5();
  av2_tile_sequencer_if b6();

  assign b5.tile_done   = tile_done;
  assign b5.recon_wr_en = recon_wr_en;
  assign b6.tile_done   = tile_done;
  assign b6.recon_wr_en = recon_wr_en;

  av2_tile_sequencer #(.TILE_LOG2(5), .TIMEOUT_CYCLES(50)) dut5 (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .frame_width(frame_width), .frame_height(frame_height),
    .busy(busy5), .frame_done(fdone5), .frame_error(ferr5), .err_tile_idx(eidx5),
    .tile_bus(b5), .tile_wr_count(twc5), .frame_wr_count(fwc5), .tiles_done(tdn5)
  );

  av2_tile_sequencer #(.TILE_LOG2(6), .TIMEOUT_CYCLES(50)) dut6 (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .frame_width(frame_width), .frame_height(frame_height),
    .busy(busy6), .frame_done(fdone6), .frame_error(ferr6), .err_tile_idx(eidx6),
    .tile_bus(b6), .tile_wr_count(twc6), .frame_wr_count(fwc6), .tiles_done(tdn6)
  );

  assign obs5 = {busy5, fdone5, ferr5, eidx5, b5.tile_start, b5.tile_x, b5.tile_y,
                 b5.tile_w, b5.tile_h, twc5, fwc5, tdn5};
  assign obs6 = {busy6, fdone6, ferr6, eidx6, b6.tile_start, b6.tile_x, b6.tile_y,
                 b6.tile_w, b6.tile_h, twc6, fwc6, tdn6};
  assign o    = sel6 ? obs6 : obs5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running, expected finish");
    $fatal(1, "simulation time limit");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, " flags"}, {o.busy, o.fdone, o.ferr, o.start}, 0);
    check({name, " geom"}, {o.x, o.y, o.w, o.h}, 0);
    check({name, " counts"}, {o.twc, o.fwc}, 0);
    check({name, " idx"}, {o.eidx, o.tdn}, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    frame_start = 1'b0;
    tile_done = 1'b0;
    recon_wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives frame_start in cycle 0 and returns at the negedge of cycle 1.
  task automatic kick(input logic [15:0] w, input logic [15:0] h);
    frame_width  = w;
    frame_height = h;
    frame_start  = 1'b1;
    @(negedge clk);
    frame_start  = 1'b0;
  endtask

  // Decoder model results.
  int          n_starts, done_pulses, err_pulses, done_cyc, err_cyc, last_td_cyc;
  logic        busy_after;
  logic [15:0] td_at_done, td_at_err, idx_at_err;
  logic [15:0] sx[16], sy[16], sw[16], sh[16];
  int          sc[16];

  // Answers tile_done lat cycles after each tile_start, except for tile index
  // `withhold`; optionally pulses frame_start (width 0) at cycle inject_at.
  task automatic serve(input int lat, input int withhold, input int inject_at, input int budget);
    int cnt;
    int end_at;
    bit fin;
    cnt = -1; end_at = -1; fin = 0;
    n_starts = 0; done_pulses = 0; err_pulses = 0;
    done_cyc = -1; err_cyc = -1; last_td_cyc = -2;
    busy_after = 1'b1; td_at_done = 16'hffff; td_at_err = 16'hffff; idx_at_err = 16'hffff;
    sc[0] = -1;
    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      tile_done   = 1'b0;
      frame_start = 1'b0;
      if (cyc == end_at) begin
        busy_after = o.busy;
        fin = 1;
      end else begin
        if (o.start) begin
          if (n_starts < 16) begin
            sx[n_starts] = o.x; sy[n_starts] = o.y;
            sw[n_starts] = o.w; sh[n_starts] = o.h;
            sc[n_starts] = cyc;
          end
          cnt = (n_starts == withhold) ? -1 : lat;
          n_starts++;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            tile_done = 1'b1;
            last_td_cyc = cyc;
            cnt = -1;
          end
        end
        if (o.fdone) begin
          done_pulses++;
          done_cyc = cyc;
          td_at_done = o.tdn;
          if (end_at < 0) end_at = cyc + 1;
        end
        if (o.ferr) begin
          err_pulses++;
          err_cyc = cyc;
          td_at_err = o.tdn;
          idx_at_err = o.eidx;
          if (end_at < 0) end_at = cyc + 1;
        end
        if (cyc == inject_at) begin
          frame_start = 1'b1;
          frame_width = '0;
        end
        @(negedge clk);
      end
    end
    tile_done   = 1'b0;
    frame_start = 1'b0;
  endtask

  typedef struct {
    logic        sel6;
    logic [15:0] w;
    logic [15:0] h;
    int          ntiles;
    int          inject;
  } frame_vec_t;

  typedef struct {
    int          frame;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
    logic [15:0] h;
  } tile_vec_t;

  frame_vec_t fv[6];
  tile_vec_t  tv[15];

  initial begin
    fv[0] = '{1'b0, 16'd64, 16'd64, 4, -1};
    fv[1] = '{1'b1, 16'd100, 16'd40, 2, -1};
    fv[2] = '{1'b0, 16'd33, 16'd1, 2, -1};
    fv[3] = '{1'b1, 16'd64, 16'd65, 2, -1};
    fv[4] = '{1'b0, 16'd1, 16'd1, 1, -1};
    fv[5] = '{1'b0, 16'd64, 16'd64, 4, 5};
    tv[0]  = '{0, 16'd0, 16'd0, 16'd32, 16'd32};
    tv[1]  = '{0, 16'd32, 16'd0, 16'd32, 16'd32};
    tv[2]  = '{0, 16'd0, 16'd32, 16'd32, 16'd32};
    tv[3]  = '{0, 16'd32, 16'd32, 16'd32, 16'd32};
    tv[4]  = '{1, 16'd0, 16'd0, 16'd64, 16'd40};
    tv[5]  = '{1, 16'd64, 16'd0, 16'd36, 16'd40};
    tv[6]  = '{2, 16'd0, 16'd0, 16'd32, 16'd1};
    tv[7]  = '{2, 16'd32, 16'd0, 16'd1, 16'd1};
    tv[8]  = '{3, 16'd0, 16'd0, 16'd64, 16'd64};
    tv[9]  = '{3, 16'd0, 16'd64, 16'd64, 16'd1};
    tv[10] = '{4, 16'd0, 16'd0, 16'd1, 16'd1};
    tv[11] = '{5, 16'd0, 16'd0, 16'd32, 16'd32};
    tv[12] = '{5, 16'd32, 16'd0, 16'd32, 16'd32};
    tv[13] = '{5, 16'd0, 16'd32, 16'd32, 16'd32};
    tv[14] = '{5, 16'd32, 16'd32, 16'd32, 16'd32};

    sel6 = 1'b0;
    frame_width = '0;
    frame_height = '0;
    @(negedge clk);
    reset_dut();

    // Reset state of both instances.
    sel6 = 1'b0; #1; check_zero("reset5");
    sel6 = 1'b1; #1; check_zero("reset6");

    // Frame table.
    for (int f = 0; f < 6; f++) begin
      int k;
      sel6 = fv[f].sel6;
      reset_dut();
      kick(fv[f].w, fv[f].h);
      serve(10, -1, fv[f].inject, 400);
      check($sformatf("f%0d starts", f), n_starts, fv[f].ntiles);
      check($sformatf("f%0d first_start_cycle", f), sc[0], 1);
      check($sformatf("f%0d done_pulses", f), done_pulses, 1);
      check($sformatf("f%0d err_pulses", f), err_pulses, 0);
      check($sformatf("f%0d done_latency", f), done_cyc, last_td_cyc + 1);
      check($sformatf("f%0d tiles_done", f), td_at_done, fv[f].ntiles);
      check($sformatf("f%0d busy_after", f), busy_after, 0);
      k = 0;
      for (int t = 0; t < 15; t++) begin
        if (tv[t].frame == f) begin
          if (k < 16)
            check($sformatf("f%0d tile%0d xywh", f, k), {sx[k], sy[k], sw[k], sh[k]},
                  {tv[t].x, tv[t].y, tv[t].w, tv[t].h});
          k++;
        end
      end
    end

    // Write counting on the 100x40 frame (TILE_LOG2=6).
    sel6 = 1'b1;
    reset_dut();
    kick(16'd100, 16'd40);                       // cycle 1: LAUNCH tile 0
    check("wr first_start", o.start, 1);
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      recon_wr_en = 1'b1;                        // 7 strobes, cycles 2..8
    end
    @(negedge clk);                              // cycle 9
    recon_wr_en = 1'b0;
    tile_done = 1'b1;
    @(negedge clk);                              // cycle 10: LAUNCH tile 1
    tile_done = 1'b0;
    check("wr tile1 launch", {o.start, o.x}, {1'b1, 16'd64});
    check("wr tile0 count", o.twc, 7);
    check("wr frame after t0", o.fwc, 7);
    @(negedge clk);                              // cycle 11
    for (int c = 12; c <= 15; c++) begin
      @(negedge clk);
      recon_wr_en = 1'b1;
    end
    @(negedge clk);                              // cycle 16: strobe with tile_done
    recon_wr_en = 1'b1;
    tile_done = 1'b1;
    @(negedge clk);                              // cycle 17: DONE, strobe ignored
    tile_done = 1'b0;
    recon_wr_en = 1'b1;
    check("wr frame_done", o.fdone, 1);
    check("wr tile1 count", o.twc, 5);
    check("wr frame count", o.fwc, 12);
    @(negedge clk);                              // cycle 18: IDLE
    recon_wr_en = 1'b0;
    check("wr idle hold", {o.busy, o.twc, o.fwc[15:0], o.tdn}, {1'b0, 32'd5, 16'd12, 16'd2});

    // Stray tile_done in IDLE.
    sel6 = 1'b0;
    reset_dut();
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    check("stray done", {o.busy, o.start, o.fdone, o.tdn}, 0);
    @(negedge clk);
    check("stray done later", {o.busy, o.start, o.fdone, o.tdn}, 0);

    // Zero-size frames.
    for (int z = 0; z < 2; z++) begin
      sel6 = z[0];
      reset_dut();
      kick((z == 0) ? 16'd0 : 16'd64, (z == 0) ? 16'd64 : 16'd0);
      check($sformatf("zero%0d cycle1", z), {o.ferr, o.busy, o.start, o.eidx}, {3'b110, 16'd0});
      @(negedge clk);
      check($sformatf("zero%0d cycle2", z), {o.ferr, o.busy, o.start}, 0);
    end

    // Reset in the middle of tile 1.
    sel6 = 1'b0;
    reset_dut();
    kick(16'd64, 16'd64);                        // cycle 1
    @(negedge clk);                              // cycle 2
    recon_wr_en = 1'b1;
    @(negedge clk);                              // cycle 3
    recon_wr_en = 1'b0;
    tile_done = 1'b1;
    @(negedge clk);                              // cycle 4
    tile_done = 1'b0;
    check("midrst launch1", {o.start, o.x}, {1'b1, 16'd32});
    @(negedge clk);                              // cycle 5
    recon_wr_en = 1'b1;
    @(negedge clk);                              // cycle 6
    recon_wr_en = 1'b0;
    check("midrst pre counts", {o.twc, o.fwc}, {32'd1, 32'd2});
    rst = 1'b1;
    @(negedge clk);                              // cycle 7
    rst = 1'b0;
    check_zero("midrst");
    @(negedge clk);
    check("midrst quiet", {o.busy, o.fdone, o.ferr, o.start}, 0);
    kick(16'd64, 16'd64);
    serve(10, -1, -1, 400);
    check("midrst restart starts", n_starts, 4);
    check("midrst restart done", {done_pulses[7:0], err_pulses[7:0], td_at_done}, {8'd1, 8'd0, 16'd4});

`ifdef AV2_TILE_SEQ_WDOG_EN
    // Watchdog on tile 2 of the 64x64 frame.
    sel6 = 1'b0;
    reset_dut();
    kick(16'd64, 16'd64);
    serve(3, 2, -1, 300);
    check("wdog starts", n_starts, 3);
    check("wdog err_latency", err_cyc, sc[2] + 51);
    check("wdog pulses", {err_pulses[7:0], done_pulses[7:0]}, {8'd1, 8'd0});
    check("wdog err_idx", idx_at_err, 2);
    check("wdog tiles_done", td_at_err, 2);
    check("wdog busy_after", busy_after, 0);
`else
    // Without the watchdog a withheld tile waits indefinitely.
    sel6 = 1'b0;
    reset_dut();
    kick(16'd64, 16'd64);
    serve(3, 2, -1, 150);
    check("nowdog starts", n_starts, 3);
    check("nowdog pulses", {err_pulses[7:0], done_pulses[7:0]}, 0);
    check("nowdog still busy", o.busy, 1);
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    serve(3, -1, -1, 100);
    check("nowdog last tile", {sx[0], sy[0]}, {16'd32, 16'd32});
    check("nowdog finish", {done_pulses[7:0], err_pulses[7:0], td_at_done}, {8'd1, 8'd0, 16'd4});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
